// File: rtl/region_mem_pkg.sv
// Shared types and default widths for the region memory controller.
package region_mem_pkg;

  localparam int unsigned DefAddrW      = 16;
  localparam int unsigned DefDataW      = 8;
  localparam int unsigned DefSelW       = 3;
  localparam int unsigned DefRegionAw   = 13;
  localparam int unsigned DefNumRegions = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DONE
  } clrState_t;

endpackage

// File: rtl/region_mem_ctrl_ram.sv
// Single-clock dual-port RAM: one write port, one enabled registered read port (read-first).
module region_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = 13
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/region_mem_ctrl.sv
// Region-split memory controller: host write port, 1-cycle read port with write-first bypass,
// unmapped-region error flags and a hardware region-clear engine.
module region_mem_ctrl
  import region_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned SEL_W       = DefSelW,
  parameter int unsigned REGION_AW   = DefRegionAw,
  parameter int unsigned NUM_REGIONS = DefNumRegions
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  input  logic              clr_start,
  input  logic [SEL_W-1:0]  clr_region,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam logic [SEL_W:0] NumRegL = (SEL_W+1)'(NUM_REGIONS);

  logic [SEL_W-1:0]     wrSel, rdSel;
  logic [REGION_AW-1:0] wrOff, rdOff;
  logic                 wrMapped, rdMapped, clrMapped, wrAccept;

  clrState_t            state;
  logic [SEL_W-1:0]     clrRegion;
  logic [DATA_W-1:0]    clrValue;
  logic [REGION_AW-1:0] clrCnt;

  logic                 memWe;
  logic [SEL_W-1:0]     memSel;
  logic [REGION_AW-1:0] memOff;
  logic [DATA_W-1:0]    memData;
  logic                 bypassHit;

  logic                 rdZeroR, bypassHitR;
  logic [SEL_W-1:0]     rdSelR;
  logic [DATA_W-1:0]    bypassDataR, rdMux;
  logic [DATA_W-1:0]    ramRdata [NUM_REGIONS];

  logic                 unusedAddr;

  // Address split; bits between select and offset fields are don't-care.
  assign wrSel      = wr_addr[ADDR_W-1 -: SEL_W];
  assign rdSel      = rd_addr[ADDR_W-1 -: SEL_W];
  assign wrOff      = wr_addr[REGION_AW-1:0];
  assign rdOff      = rd_addr[REGION_AW-1:0];
  assign wrMapped   = {1'b0, wrSel} < NumRegL;
  assign rdMapped   = {1'b0, rdSel} < NumRegL;
  assign clrMapped  = {1'b0, clr_region} < NumRegL;
  assign unusedAddr = ^{wr_addr, rd_addr};

  assign wr_ready = !rst && (state == ST_IDLE);
  assign wrAccept = wr_valid && wr_ready;

  // Write source: the clear engine owns the RAM write port while clearing.
  always_comb begin
    memWe   = wrAccept && wrMapped;
    memSel  = wrSel;
    memOff  = wrOff;
    memData = wr_data;
    if (state == ST_CLEAR) begin
      memWe   = 1'b1;
      memSel  = clrRegion;
      memOff  = clrCnt;
      memData = clrValue;
    end
  end

  assign bypassHit = memWe && rdMapped && (memSel == rdSel) && (memOff == rdOff);

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : gRam
    region_ram #(
      .DATA_W(DATA_W),
      .AW    (REGION_AW)
    ) uRam (
      .clk  (clk),
      .we   (memWe && (memSel == SEL_W'(g))),
      .waddr(memOff),
      .wdata(memData),
      .re   (rd_req),
      .raddr(rdOff),
      .rdata(ramRdata[g])
    );
  end

  // Clear engine: IDLE -> CLEAR (one word per cycle) -> DONE -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      clrCnt    <= '0;
      clrRegion <= '0;
      clrValue  <= '0;
      clr_busy  <= 1'b0;
      clr_done  <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clr_start && clrMapped) begin
            state     <= ST_CLEAR;
            clrRegion <= clr_region;
            clrValue  <= clr_value;
            clrCnt    <= '0;
            clr_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          clrCnt <= clrCnt + REGION_AW'(1);
          if (clrCnt == '1) begin
            state    <= ST_DONE;
            clr_done <= 1'b1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          clr_busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_err <= 1'b0;
    else     wr_err <= wrAccept && !wrMapped;
  end

  // Read-side context is captured only on a request so outputs hold between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid    <= 1'b0;
      rd_err      <= 1'b0;
      rdZeroR     <= 1'b1;
      rdSelR      <= '0;
      bypassHitR  <= 1'b0;
      bypassDataR <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_err      <= !rdMapped;
        rdZeroR     <= !rdMapped;
        rdSelR      <= rdSel;
        bypassHitR  <= bypassHit;
        bypassDataR <= memData;
      end
    end
  end

  always_comb begin
    rdMux = '0;
    for (int unsigned r = 0; r < NUM_REGIONS; r++) begin
      if (rdSelR == SEL_W'(r)) rdMux = ramRdata[r];
    end
    if (rdZeroR)         rd_data = '0;
    else if (bypassHitR) rd_data = bypassDataR;
    else                 rd_data = rdMux;
  end

endmodule

// File: tb/tb_region_mem_ctrl.sv
// Directed and randomized check of region_mem_ctrl against an array-based memory model.
module tb_region_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0, wr_ready, wr_err;
  logic [15:0] wr_addr = '0, rd_addr = '0;
  logic [7:0]  wr_data = '0, rd_data, clr_value = '0;
  logic        rd_req = 1'b0, rd_valid, rd_err;
  logic        clr_start = 1'b0, clr_busy, clr_done;
  logic [2:0]  clr_region = '0;

  int errors = 0;
  int checks = 0;

  logic [7:0] model [2][16];
  logic [7:0] lastData;
  logic       lastErr;

  region_mem_ctrl #(
    .ADDR_W(16), .DATA_W(8), .SEL_W(3), .REGION_AW(4), .NUM_REGIONS(2)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .clr_start(clr_start), .clr_region(clr_region), .clr_value(clr_value),
    .clr_busy(clr_busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic isMap(input logic [15:0] a);
    return a[15:13] < 3'd2;
  endfunction

  function automatic logic [7:0] mget(input logic [15:0] a);
    if (!isMap(a)) return 8'h00;
    return model[int'(a[15:13])][int'(a[3:0])];
  endfunction

  task automatic mset(input logic [15:0] a, input logic [7:0] d);
    if (isMap(a)) model[int'(a[15:13])][int'(a[3:0])] = d;
  endtask

  task automatic doWrite(input logic [15:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    mset(a, d);
    tick();
    wr_valid = 1'b0;
    chk("wr_err", wr_err, !isMap(a));
  endtask

  task automatic doRead(input logic [15:0] a);
    rd_req   = 1'b1;
    rd_addr  = a;
    lastData = mget(a);
    lastErr  = !isMap(a);
    tick();
    rd_req = 1'b0;
    chk("rd_valid", rd_valid, 1'b1);
    chk("rd_data", rd_data, lastData);
    chk("rd_err", rd_err, lastErr);
  endtask

  task automatic dumpAll();
    for (int r = 0; r < 2; r++)
      for (int o = 0; o < 16; o++)
        doRead(16'((r << 13) | o));
  endtask

  initial begin
    logic [7:0]  v;
    logic [15:0] a, ra;
    logic        wv, rq;
    int          n;

    // Reset values
    #1;
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_rd_err", rd_err, 1'b0);
    chk("rst_wr_err", wr_err, 1'b0);
    chk("rst_clr_busy", clr_busy, 1'b0);
    chk("rst_clr_done", clr_done, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("wr_ready_after_rst", wr_ready, 1'b1);

    // Fill both regions with random data
    for (int r = 0; r < 2; r++)
      for (int o = 0; o < 16; o++)
        doWrite(16'((r << 13) | o), 8'($urandom));

    // Test 1: basic write/read in both regions
    doWrite(16'h0005, 8'h41);
    doWrite(16'h2005, 8'h3C);
    doRead(16'h0005);
    chk("t1_data0", rd_data, 8'h41);
    doRead(16'h2005);
    chk("t1_data1", rd_data, 8'h3C);
    tick();
    chk("t1_idle_valid", rd_valid, 1'b0);
    chk("t1_hold_data", rd_data, 8'h3C);

    // Test 2: same-edge write and read returns the new data
    doWrite(16'h2003, 8'h11);
    wr_valid = 1'b1; wr_addr = 16'h2003; wr_data = 8'h7E;
    rd_req   = 1'b1; rd_addr = 16'h2003;
    mset(16'h2003, 8'h7E);
    tick();
    wr_valid = 1'b0; rd_req = 1'b0;
    chk("t2_valid", rd_valid, 1'b1);
    chk("t2_bypass", rd_data, 8'h7E);

    // Test 3: unmapped write and read
    doWrite(16'h4000, 8'h55);
    tick();
    chk("t3_wr_err_pulse", wr_err, 1'b0);
    doRead(16'h4000);
    chk("t3_rd_err", rd_err, 1'b1);
    chk("t3_rd_zero", rd_data, 8'h00);

    // Unmapped clear request is ignored
    clr_start = 1'b1; clr_region = 3'd2; clr_value = 8'h99;
    tick();
    clr_start = 1'b0;
    chk("unmapped_clr_busy", clr_busy, 1'b0);
    chk("unmapped_clr_ready", wr_ready, 1'b1);

    // Test 4: clear region 1 with 0xAA
    clr_start = 1'b1; clr_region = 3'd1; clr_value = 8'hAA;
    tick();
    clr_start = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      chk("t4_busy", clr_busy, 1'b1);
      chk("t4_ready", wr_ready, 1'b0);
      chk("t4_done", clr_done, (i == 17));
      clr_start  = (i == 3);
      clr_region = 3'd0;
      clr_value  = 8'h00;
      wr_valid   = (i == 5);
      wr_addr    = 16'h0001;
      wr_data    = 8'hEE;
      tick();
    end
    clr_start = 1'b0; wr_valid = 1'b0;
    chk("t4_busy_end", clr_busy, 1'b0);
    chk("t4_done_end", clr_done, 1'b0);
    chk("t4_ready_end", wr_ready, 1'b1);
    for (int o = 0; o < 16; o++) model[1][o] = 8'hAA;
    dumpAll();

    // Test 5: reset during the 6th clear cycle, with a same-edge host write at start
    v = 8'($urandom);
    clr_start = 1'b1; clr_region = 3'd0; clr_value = 8'hFF;
    wr_valid  = 1'b1; wr_addr = 16'h2007; wr_data = v;
    mset(16'h2007, v);
    tick();
    clr_start = 1'b0; wr_valid = 1'b0;
    chk("t5_busy", clr_busy, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", clr_busy, 1'b0);
    chk("t5_rst_done", clr_done, 1'b0);
    chk("t5_rst_ready", wr_ready, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_ready_after", wr_ready, 1'b1);
    chk("t5_busy_after", clr_busy, 1'b0);
    for (int o = 0; o < 5; o++) model[0][o] = 8'hFF;
    dumpAll();

    // Test 6: continuous region-1 sweep while region 0 is being cleared
    v = 8'($urandom);
    clr_start = 1'b1; clr_region = 3'd0; clr_value = v;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd_req  = 1'b1;
      rd_addr = 16'(16'h2000 + i);
      lastData = model[1][i];
      lastErr  = 1'b0;
      tick();
      chk("t6_valid", rd_valid, 1'b1);
      chk("t6_data", rd_data, lastData);
      chk("t6_err", rd_err, 1'b0);
    end
    rd_req = 1'b0;
    n = 0;
    while (!clr_done && n < 40) begin
      tick();
      n++;
    end
    chk("t6_done_seen", clr_done, 1'b1);
    tick();
    for (int o = 0; o < 16; o++) model[0][o] = v;
    dumpAll();

    // Randomized host traffic, including unmapped selects and ignored middle address bits
    for (int i = 0; i < 300; i++) begin
      wv = 1'($urandom);
      rq = 1'($urandom);
      a  = {3'($urandom_range(0, 3)), 9'($urandom), 4'($urandom)};
      ra = {3'($urandom_range(0, 3)), 9'($urandom), 4'($urandom)};
      if ($urandom_range(0, 3) == 0) ra = a;
      v  = 8'($urandom);
      wr_valid = wv; wr_addr = a; wr_data = v;
      rd_req   = rq; rd_addr = ra;
      if (wv) mset(a, v);
      if (rq) begin
        lastData = mget(ra);
        lastErr  = !isMap(ra);
      end
      tick();
      chk("rnd_wr_err", wr_err, wv && !isMap(a));
      chk("rnd_rd_valid", rd_valid, rq);
      chk("rnd_rd_data", rd_data, lastData);
      chk("rnd_rd_err", rd_err, lastErr);
    end
    wr_valid = 1'b0; rd_req = 1'b0;
    dumpAll();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
